// File: rtl/div_manager.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) with a one-entry
// pending-destination scoreboard and a valid/ready writeback port.
module div_manager #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     div_req_i,
  input  logic [1:0]               div_op_i,
  input  logic [DATA_W-1:0]        dividend_i,
  input  logic [DATA_W-1:0]        divisor_i,
  input  logic [REG_ADDR_W-1:0]    rd_addr_i,
  output logic                     div_busy_o,
  output logic [2**REG_ADDR_W-1:0] rd_addr_flags_o,
  output logic                     wb_valid_o,
  output logic [REG_ADDR_W-1:0]    wb_rd_addr_o,
  output logic [DATA_W-1:0]        wb_data_o,
  input  logic                     wb_ready_i
);

  localparam int NREG = 2**REG_ADDR_W;

  // state  | meaning
  // IDLE   | waiting for a request
  // CALC   | restoring division, one quotient bit per cycle
  // DONE   | result presented, waiting for writeback grant
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]       rem_q, rem_d;
  logic [DATA_W-1:0]       quo_q, quo_d;
  logic [DATA_W-1:0]       dvs_q, dvs_d;
  logic [DATA_W-1:0]       res_q, res_d;
  logic                    is_rem_q, is_rem_d;
  logic                    negq_q, negq_d;
  logic                    negr_q, negr_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [NREG-1:0]         flags_q, flags_d;

  logic                    signed_op, a_neg, b_neg, div_zero, ovf, accept;
  logic [DATA_W-1:0]       a_mag, b_mag;
  logic [NREG-1:0]         rd_onehot;
  logic [DATA_W:0]         rem_shift, diff;
  logic                    ge;
  logic [DATA_W-1:0]       rem_next, quo_next, q_fix, r_fix;

  assign signed_op = ~div_op_i[0];
  assign a_neg     = signed_op & dividend_i[DATA_W-1];
  assign b_neg     = signed_op & divisor_i[DATA_W-1];
  assign a_mag     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign b_mag     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign ovf       = signed_op && (dividend_i == {1'b1, {(DATA_W-1){1'b0}}})
                     && (divisor_i == '1);
  assign accept    = (state_q == S_IDLE) && div_req_i && (rd_addr_i != '0);
  assign rd_onehot = {{(NREG-1){1'b0}}, 1'b1} << rd_addr_i;

  // One restoring step: shift next dividend bit into the partial remainder.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign ge        = ~diff[DATA_W];
  assign rem_next  = ge ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
  assign quo_next  = {quo_q[DATA_W-2:0], ge};
  assign q_fix     = negq_q ? (~quo_next + 1'b1) : quo_next;
  assign r_fix     = negr_q ? (~rem_next + 1'b1) : rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      is_rem_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      rd_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      is_rem_q <= is_rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      rd_q     <= rd_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    is_rem_d = is_rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    rd_d     = rd_q;
    flags_d  = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d     = rd_addr_i;
          flags_d  = rd_onehot;
          is_rem_d = div_op_i[1];
          if (div_zero || ovf) begin
            // Architectural special results skip the iteration entirely.
            if (div_zero) res_d = div_op_i[1] ? dividend_i : '1;
            else          res_d = div_op_i[1] ? '0 : dividend_i;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = 5'd31;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        if (cnt_q == 5'd0) begin
          res_d   = is_rem_q ? r_fix : q_fix;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DONE: begin
        if (wb_ready_i) begin
          flags_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign div_busy_o      = (state_q != S_IDLE);
  assign wb_valid_o      = (state_q == S_DONE);
  assign wb_rd_addr_o    = rd_q;
  assign wb_data_o       = res_q;
  // Cycle-0 bypass so ID stalls on the destination before the bit is registered.
  assign rd_addr_flags_o = flags_q | ((accept && !rst) ? rd_onehot : '0);

endmodule

// File: tb/tb_div_manager.sv
// Self-checking bench for div_manager: directed cases with literal results plus
// randomized ops compared every cycle against an arithmetic reference model.
module tb_div_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i;
  logic [1:0]  div_op_i;
  logic [31:0] dividend_i, divisor_i;
  logic [4:0]  rd_addr_i;
  logic        div_busy_o;
  logic [31:0] rd_addr_flags_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_ready_i;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  div_manager #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .div_req_i(div_req_i), .div_op_i(div_op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .div_busy_o(div_busy_o), .rd_addr_flags_o(rd_addr_flags_o),
    .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
    .wb_ready_i(wb_ready_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Reference model: one op in flight, result valid 1 or 33 cycles after acceptance.
  logic        m_busy;
  int          m_cyc, m_lat;
  logic [4:0]  m_rd;
  logic [31:0] m_res, m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_cyc <= 0; m_lat <= 0;
      m_rd <= '0; m_res <= '0; m_last <= '0;
    end else if (!m_busy) begin
      if (div_req_i && rd_addr_i != 5'd0) begin
        m_busy <= 1'b1;
        m_cyc  <= 1;
        m_lat  <= is_special(div_op_i, dividend_i, divisor_i) ? 1 : 33;
        m_rd   <= rd_addr_i;
        m_res  <= ref_div(div_op_i, dividend_i, divisor_i);
      end
    end else if (m_cyc >= m_lat) begin
      if (wb_ready_i) begin
        m_busy <= 1'b0;
        m_last <= m_res;
      end
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  logic        e_valid;
  logic [31:0] e_flags;
  always @(negedge clk) begin
    if (cmp_en) begin
      e_valid = m_busy && (m_cyc >= m_lat);
      e_flags = (m_busy ? (32'd1 << m_rd) : 32'd0)
              | ((!m_busy && !rst && div_req_i && rd_addr_i != 5'd0) ? (32'd1 << rd_addr_i) : 32'd0);
      chk("cmp_busy",  32'(div_busy_o), 32'(m_busy));
      chk("cmp_valid", 32'(wb_valid_o), 32'(e_valid));
      chk("cmp_flags", rd_addr_flags_o, e_flags);
      chk("cmp_data",  wb_data_o, e_valid ? m_res : m_last);
      if (e_valid) chk("cmp_rd", 32'(wb_rd_addr_o), 32'(m_rd));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (div_busy_o && n < 300) begin step(); n++; end
    if (n >= 300) chk("wait_idle_timeout", 32'(n), 32'd0);
  endtask

  // Returns the cycle index (acceptance = 0) in which wb_valid_o is first seen.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!wb_valid_o && cyc < 100) begin step(); cyc++; end
  endtask

  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat);
    int cyc;
    wait_idle();
    div_req_i = 1'b1; div_op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    #1 chk({nm, "_flag_c0"}, rd_addr_flags_o, 32'd1 << rd);
    step();
    div_req_i = 1'b0;
    wait_valid(cyc);
    chk({nm, "_latency"}, 32'(cyc), 32'(lat));
    chk({nm, "_data"}, wb_data_o, exp);
    chk({nm, "_rd"}, 32'(wb_rd_addr_o), 32'(rd));
    step();
    chk({nm, "_flag_after"}, rd_addr_flags_o, 32'd0);
    chk({nm, "_idle_after"}, 32'(div_busy_o), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, n;
    rst = 1'b1; div_req_i = 1'b0; div_op_i = 2'b00; dividend_i = '0; divisor_i = '0;
    rd_addr_i = '0; wb_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(div_busy_o), 32'd0);
    chk("rst_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_flags", rd_addr_flags_o, 32'd0);
    chk("rst_data",  wb_data_o, 32'd0);
    chk("rst_rd",    32'(wb_rd_addr_o), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    step();

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33);
    do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 33);
    do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33);
    do_op("remu_big_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1, 33);
    do_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, 33);
    do_op("div_by0",    2'b00, 32'd42, 32'd0, 5'd3, 32'hFFFF_FFFF, 1);
    do_op("rem_by0",    2'b10, 32'd42, 32'd0, 5'd3, 32'd42, 1);
    do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 1);
    do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'd0, 1);

    // Backpressure with a second request arriving during the hold.
    wb_ready_i = 1'b0;
    div_req_i = 1'b1; div_op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd5;
    step();
    div_req_i = 1'b0;
    wait_valid(cyc);
    chk("bp_latency", 32'(cyc), 32'd33);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        div_req_i = 1'b1; div_op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5; rd_addr_i = 5'd7;
      end
      step();
      chk("bp_hold_valid", 32'(wb_valid_o), 32'd1);
      chk("bp_hold_data", wb_data_o, 32'd14);
      chk("bp_hold_flags", rd_addr_flags_o, 32'h0000_0020);
      chk("bp_hold_busy", 32'(div_busy_o), 32'd1);
    end
    wb_ready_i = 1'b1;
    step();
    chk("bp_post_hs_busy", 32'(div_busy_o), 32'd0);
    chk("bp_post_hs_flags", rd_addr_flags_o, 32'h0000_0080);
    step();
    div_req_i = 1'b0;
    chk("bp_second_busy", 32'(div_busy_o), 32'd1);
    wait_valid(cyc);
    chk("bp_second_latency", 32'(cyc), 32'd33);
    chk("bp_second_data", wb_data_o, 32'd10);
    step();

    // Asynchronous reset in the middle of CALC.
    wait_idle();
    div_req_i = 1'b1; div_op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd7; rd_addr_i = 5'd9;
    step();
    div_req_i = 1'b0;
    repeat (14) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  32'(div_busy_o), 32'd0);
    chk("arst_valid", 32'(wb_valid_o), 32'd0);
    chk("arst_flags", rd_addr_flags_o, 32'd0);
    chk("arst_data",  wb_data_o, 32'd0);
    chk("arst_rd",    32'(wb_rd_addr_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd2, 32'd3, 33);

    // rd = 0 is dropped; the next request is taken the following cycle.
    div_req_i = 1'b1; div_op_i = 2'b00; dividend_i = 32'd5; divisor_i = 32'd1; rd_addr_i = 5'd0;
    #1 chk("rd0_flags", rd_addr_flags_o, 32'd0);
    step();
    chk("rd0_busy", 32'(div_busy_o), 32'd0);
    rd_addr_i = 5'd4;
    #1 chk("rd0_next_flags", rd_addr_flags_o, 32'h0000_0010);
    step();
    div_req_i = 1'b0;
    chk("rd0_next_busy", 32'(div_busy_o), 32'd1);
    wait_valid(cyc);
    chk("rd0_next_data", wb_data_o, 32'd5);
    step();

    // Randomized ops with random writeback backpressure.
    for (int i = 0; i < 40; i++) begin
      wait_idle();
      div_req_i  = 1'b1;
      div_op_i   = 2'($urandom_range(0, 3));
      dividend_i = pick_operand();
      divisor_i  = pick_operand();
      rd_addr_i  = 5'($urandom_range(0, 31));
      step();
      div_req_i = 1'b0;
      n = 0;
      while (div_busy_o && n < 300) begin
        wb_ready_i = ($urandom_range(0, 3) != 0);
        step();
        n++;
      end
      if (n >= 300) chk("rand_timeout", 32'(n), 32'd0);
      wb_ready_i = 1'b1;
      step();
    end

    wait_idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
